// File: rtl/fp32_acc_seq.sv
// FP32 packet accumulator: streams operands through a combinational add/sub unit
// into a running sum and hands the total downstream over a valid/ready handshake.

module FP_32_add_or_sub (
    input  logic [31:0] add1,
    input  logic [31:0] add2,
    input  logic        command,
    output logic [31:0] result
);
    logic              sign_a, sign_b, sign_r;
    logic [30:0]       mag_a, mag_b, mag_big, mag_small;
    logic [7:0]        exp_big, exp_small, exp_diff;
    logic [27:0]       man_big, man_small, man_shift, man_sum, man_norm;
    logic [4:0]        lz;
    logic signed [9:0] exp_r;

    function automatic logic [4:0] lead_zeros(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    always_comb begin
        sign_a = add1[31];
        sign_b = add2[31] ^ ~command;
        mag_a  = add1[30:0];
        mag_b  = add2[30:0];
        // Larger magnitude operand sets the result sign and reference exponent.
        if (mag_b > mag_a) begin
            mag_big = mag_b; mag_small = mag_a; sign_r = sign_b;
        end else begin
            mag_big = mag_a; mag_small = mag_b; sign_r = sign_a;
        end
        exp_big   = mag_big[30:23];
        exp_small = mag_small[30:23];
        exp_diff  = exp_big - exp_small;
        // Exponent 0 is flushed to zero; three guard bits below the mantissa.
        man_big   = (exp_big   != 8'd0) ? {2'b01, mag_big[22:0],   3'b000} : 28'd0;
        man_small = (exp_small != 8'd0) ? {2'b01, mag_small[22:0], 3'b000} : 28'd0;
        man_shift = (exp_diff > 8'd27) ? 28'd0 : (man_small >> exp_diff);
        man_sum   = (sign_a == sign_b) ? (man_big + man_shift) : (man_big - man_shift);
        lz        = lead_zeros(man_sum[26:0]);
        if (man_sum[27]) begin
            man_norm = man_sum >> 1;
            exp_r    = $signed({2'b00, exp_big}) + 10'sd1;
        end else begin
            man_norm = man_sum << lz;
            exp_r    = $signed({2'b00, exp_big}) - $signed({5'b00000, lz});
        end
        if (man_sum == 28'd0) begin
            result = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            result = {sign_r, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result = {sign_r, 31'd0};
        end else begin
            result = {sign_r, exp_r[7:0], man_norm[25:3]};
        end
    end
endmodule

module fp32_acc_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_cmd,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_special
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc, acc_d, sum;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               spec, spec_d;
    logic               accept, is_special;

    FP_32_add_or_sub u_addsub (
        .add1    (acc),
        .add2    (in_data),
        .command (in_cmd),
        .result  (sum)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc;
        cnt_d      = cnt;
        spec_d     = spec;
        out_valid  = 1'b0;
        in_ready   = (state_q != DONE);
        accept     = in_valid & in_ready;
        is_special = (in_data[30:23] == 8'hFF);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // First beat bypasses the adder; subtraction is a sign flip.
                    acc_d   = in_cmd ? in_data : {~in_data[31], in_data[30:0]};
                    cnt_d   = CNT_W'(1);
                    spec_d  = is_special;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d  = sum;
                    cnt_d  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
                    spec_d = spec | is_special;
                    if (in_last) state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc     <= 32'd0;
            cnt     <= '0;
            spec    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            spec    <= spec_d;
        end
    end

    assign out_data    = acc;
    assign out_count   = cnt;
    assign out_special = spec;
endmodule

// File: tb/tb_fp32_acc_seq.sv
// Scoreboard bench for fp32_acc_seq: directed packets push expected sums,
// an independent monitor checks every completed output handshake.

module tb_fp32_acc_seq;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_cmd, in_last;
    logic [31:0]      in_data;
    logic             out_valid, out_ready, out_special;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    typedef struct {
        logic [31:0]      data;
        logic [CNT_W-1:0] count;
        logic             special;
        logic             chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fp32_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_cmd      (in_cmd),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_special (out_special)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input int c, input logic s, input logic cd);
        exp_t e;
        e.data = d; e.count = CNT_W'(c); e.special = s; e.chk_data = cd;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic c, input logic l);
        int waited = 0;
        in_valid = 1'b1; in_data = d; in_cmd = c; in_last = l;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // After the last beat: one DONE cycle with out_ready high.
    task automatic finish_pkt();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_data, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) chk("out_data", out_data, e.data);
                chk("out_count", {{(32-CNT_W){1'b0}}, out_count}, {{(32-CNT_W){1'b0}}, e.count});
                chk("out_special", {31'd0, out_special}, {31'd0, e.special});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_cmd = 1'b1; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", {24'd0, out_count}, 32'd0);
        chk("rst_out_special", {31'd0, out_special}, 32'd0);
        @(posedge clk); #1;

        // 1 + 2 + 3 back-to-back
        send(32'h3F800000, 1'b1, 1'b0);
        send(32'h40000000, 1'b1, 1'b0);
        push(32'h40C00000, 3, 1'b0, 1'b1);
        send(32'h40400000, 1'b1, 1'b1);
        finish_pkt();

        // 5 - 2 with an idle gap (in_last high but no beat) mid-packet
        send(32'h40A00000, 1'b1, 1'b0);
        in_valid = 1'b0; in_last = 1'b1;
        @(posedge clk); #1;
        push(32'h40400000, 2, 1'b0, 1'b1);
        send(32'h40000000, 1'b0, 1'b1);
        finish_pkt();

        // single-beat subtract
        push(32'hBF800000, 1, 1'b0, 1'b1);
        send(32'h3F800000, 1'b0, 1'b1);
        finish_pkt();

        // 1 - 3 gives a negative result
        send(32'h3F800000, 1'b1, 1'b0);
        push(32'hC0000000, 2, 1'b0, 1'b1);
        send(32'h40400000, 1'b0, 1'b1);
        finish_pkt();

        // backpressure: out_ready low for three DONE cycles
        send(32'h3F800000, 1'b1, 1'b0);
        out_ready = 1'b0;
        push(32'h40000000, 2, 1'b0, 1'b1);
        send(32'h3F800000, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = 32'h40000000; in_cmd = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_data", out_data, 32'h40000000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_in_ready", {31'd0, in_ready}, 32'd0);
        push(32'h40000000, 1, 1'b0, 1'b1);
        send(32'h40000000, 1'b1, 1'b1);
        finish_pkt();

        // reset in the middle of a packet
        send(32'h3F800000, 1'b1, 1'b0);
        send(32'h40000000, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_count", {24'd0, out_count}, 32'd0);
        @(posedge clk); #1;
        push(32'h40400000, 1, 1'b0, 1'b1);
        send(32'h40400000, 1'b1, 1'b1);
        finish_pkt();

        // Inf operand flags the packet; sum value is not checked
        send(32'h7F800000, 1'b1, 1'b0);
        push(32'h0, 2, 1'b1, 1'b0);
        send(32'h3F800000, 1'b1, 1'b1);
        finish_pkt();
        send(32'h3F800000, 1'b1, 1'b0);
        push(32'h40000000, 2, 1'b0, 1'b1);
        send(32'h3F800000, 1'b1, 1'b1);
        finish_pkt();

        // 260 beats of 1.0: sum 260.0, counter saturates at 255
        for (int i = 0; i < 259; i++) send(32'h3F800000, 1'b1, 1'b0);
        push(32'h43820000, 255, 1'b0, 1'b1);
        send(32'h3F800000, 1'b1, 1'b1);
        finish_pkt();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
